lcd_text_frame: RTL and testbench

- Upstream feeder for the LCD driver: holds a 2x16 character frame and streams it to the driver as command/data words over a valid/ready handshake.
- Host logic (counters, status LEDs, future UART) writes characters by cell address.
- The block emits each frame as: set-DDRAM-address row 0, 16 characters, set-DDRAM-address row 1, 16 characters.
- Replaces hard-coded data tables at the top level.

---
 rtl/lcd_defs_pkg.sv | 36 +++
 rtl/lcd_char_ram.sv | 46 ++++
 rtl/lcd_text_frame.sv | 154 +++++++++++++++
 tb/tb_lcd_text_frame.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_defs_pkg.sv
// -----------------------------------------------------------------------------
// lcd_defs
// Shared constants and types for the LCD text-frame feeder and its helpers.
//   - Frame geometry (COLS x ROWS), the DDRAM set-address commands for each row,
//     the blank fill character and the RS encodings for command/data words.
//   - CLEAR_CMD is the clear-display command used by the downstream driver.
//   - state_t enumerates the frame-streaming FSM states.
// -----------------------------------------------------------------------------
package lcd_defs;

    localparam int COLS  = 16;
    localparam int ROWS  = 2;
    localparam int CELLS = COLS * ROWS;

    localparam logic [7:0] ROW0_CMD  = 8'h80;
    localparam logic [7:0] ROW1_CMD  = 8'hC0;
    localparam logic [7:0] BLANK     = 8'h20;
    localparam logic [7:0] CLEAR_CMD = 8'h01;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD0,
        ST_ROW0,
        ST_CMD1,
        ST_ROW1
    } state_t;

    // Build a driver word {RS, data}.
    function automatic logic [8:0] mkWord(input logic rs, input logic [7:0] data);
        return {rs, data};
    endfunction

endpackage

// File: rtl/lcd_char_ram.sv
// -----------------------------------------------------------------------------
// lcd_char_ram
// 32 x 8 character buffer holding the 2x16 display frame.
// Ports:
//   clk       in   system clock
//   rstBt     in   asynchronous active-low reset, all cells -> BLANK
//   wrEn_i    in   write strobe, cell[wrAddr_i] <= wrData_i
//   wrAddr_i  in   cell index row*16+col
//   wrData_i  in   character code
//   clrReq_i  in   fill every cell with BLANK; overrides a same-cycle write
//   rdAddr_i  in   combinational read address
//   rdData_o  out  cell[rdAddr_i] (pre-write value within a cycle)
// -----------------------------------------------------------------------------
module lcd_char_ram
    import lcd_defs::*;
(
    input  logic       clk,
    input  logic       rstBt,
    input  logic       wrEn_i,
    input  logic [4:0] wrAddr_i,
    input  logic [7:0] wrData_i,
    input  logic       clrReq_i,
    input  logic [4:0] rdAddr_i,
    output logic [7:0] rdData_o
);

    logic [7:0] cells_q [CELLS];

    // Clear has priority over a write issued in the same cycle.
    always_ff @(posedge clk or negedge rstBt) begin
        if (!rstBt) begin
            for (int i = 0; i < CELLS; i++) begin
                cells_q[i] <= BLANK;
            end
        end else if (clrReq_i) begin
            for (int i = 0; i < CELLS; i++) begin
                cells_q[i] <= BLANK;
            end
        end else if (wrEn_i) begin
            cells_q[wrAddr_i] <= wrData_i;
        end
    end

    assign rdData_o = cells_q[rdAddr_i];

endmodule

// File: rtl/lcd_text_frame.sv
// -----------------------------------------------------------------------------
// lcd_text_frame
// Holds a 2x16 character frame and streams it to the LCD driver as
// {RS,data} words over a valid/ready handshake:
//   {0,80h}, 16 x row-0 chars, {0,C0h}, 16 x row-1 chars.
// Ports:
//   clk         in   system clock
//   rstBt       in   asynchronous active-low reset
//   wrEn        in   host character write strobe
//   wrAddr[4:0] in   cell index row*16+col
//   wrData[7:0] in   character code
//   clrReq      in   fill all cells with BLANK
//   refreshReq  in   request one frame
//   outWord[8:0]out  {RS, data}
//   outValid    out  outWord is valid
//   outReady    in   driver accepts outWord this cycle
//   busy        out  frame in progress
//   frameDone   out  one-cycle pulse after the last beat is accepted
// -----------------------------------------------------------------------------
module lcd_text_frame
    import lcd_defs::*;
(
    input  logic       clk,
    input  logic       rstBt,
    input  logic       wrEn,
    input  logic [4:0] wrAddr,
    input  logic [7:0] wrData,
    input  logic       clrReq,
    input  logic       refreshReq,
    output logic [8:0] outWord,
    output logic       outValid,
    input  logic       outReady,
    output logic       busy,
    output logic       frameDone
);

    localparam logic [3:0] LAST_COL = 4'(COLS - 1);

    state_t     state_q, state_d;
    logic [3:0] col_q, col_d;
    logic [8:0] word_q, word_d;
    logic       pending_q, pending_d;
    logic       frameDone_q, frameDone_d;
    logic [4:0] rdAddr;
    logic [7:0] rdData;
    logic [3:0] colNext;

    lcd_char_ram u_ram (
        .clk      (clk),
        .rstBt    (rstBt),
        .wrEn_i   (wrEn),
        .wrAddr_i (wrAddr),
        .wrData_i (wrData),
        .clrReq_i (clrReq),
        .rdAddr_i (rdAddr),
        .rdData_o (rdData)
    );

    assign colNext = col_q + 4'd1;

    // State register plus the registered word, column and flags.
    always_ff @(posedge clk or negedge rstBt) begin
        if (!rstBt) begin
            state_q     <= ST_IDLE;
            col_q       <= 4'd0;
            word_q      <= 9'h000;
            pending_q   <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            word_q      <= word_d;
            pending_q   <= pending_d;
            frameDone_q <= frameDone_d;
        end
    end

    // Next-state logic. The read address always points at the cell that would
    // be loaded on the next accepted beat, so the word is captured from the
    // buffer's pre-write contents on the same edge as the transfer.
    // Any request arriving while a frame runs leaves a pending frame behind.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        word_d      = word_q;
        frameDone_d = 1'b0;
        rdAddr      = 5'd0;
        pending_d   = pending_q |
                      ((state_q != ST_IDLE) & (refreshReq | wrEn | clrReq));

        case (state_q)
            ST_IDLE: begin
                if (refreshReq || pending_q) begin
                    state_d   = ST_CMD0;
                    word_d    = mkWord(RS_CMD, ROW0_CMD);
                    pending_d = 1'b0;
                end
            end
            ST_CMD0: begin
                rdAddr = 5'd0;
                if (outReady) begin
                    state_d = ST_ROW0;
                    col_d   = 4'd0;
                    word_d  = mkWord(RS_DATA, rdData);
                end
            end
            ST_ROW0: begin
                rdAddr = {1'b0, colNext};
                if (outReady) begin
                    if (col_q == LAST_COL) begin
                        state_d = ST_CMD1;
                        word_d  = mkWord(RS_CMD, ROW1_CMD);
                    end else begin
                        col_d  = colNext;
                        word_d = mkWord(RS_DATA, rdData);
                    end
                end
            end
            ST_CMD1: begin
                rdAddr = 5'd16;
                if (outReady) begin
                    state_d = ST_ROW1;
                    col_d   = 4'd0;
                    word_d  = mkWord(RS_DATA, rdData);
                end
            end
            ST_ROW1: begin
                rdAddr = {1'b1, colNext};
                if (outReady) begin
                    if (col_q == LAST_COL) begin
                        state_d     = ST_IDLE;
                        frameDone_d = 1'b1;
                    end else begin
                        col_d  = colNext;
                        word_d = mkWord(RS_DATA, rdData);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: valid and busy cover every non-idle state, so valid never
    // drops mid-frame and the held word stays stable during stalls.
    always_comb begin
        outValid  = (state_q != ST_IDLE);
        busy      = (state_q != ST_IDLE);
        outWord   = word_q;
        frameDone = frameDone_q;
    end

endmodule

// File: tb/tb_lcd_text_frame.sv
// -----------------------------------------------------------------------------
// tb_lcd_text_frame
// Directed bench for lcd_text_frame. A character model mirrors host writes;
// each requested frame is pushed to a queue of expected words and every
// accepted beat pops and compares one entry.
// -----------------------------------------------------------------------------
module tb_lcd_text_frame;

    logic       clk;
    logic       rstBt;
    logic       wrEn;
    logic [4:0] wrAddr;
    logic [7:0] wrData;
    logic       clrReq;
    logic       refreshReq;
    logic [8:0] outWord;
    logic       outValid;
    logic       outReady;
    logic       busy;
    logic       frameDone;

    logic [8:0] expQ [$];
    logic [7:0] model [32];
    logic [8:0] expWord;
    logic [8:0] prevWord;
    logic       stallPrev;
    int         assertCount;
    int         failCount;
    int         beatCount;

    lcd_text_frame dut (
        .clk        (clk),
        .rstBt      (rstBt),
        .wrEn       (wrEn),
        .wrAddr     (wrAddr),
        .wrData     (wrData),
        .clrReq     (clrReq),
        .refreshReq (refreshReq),
        .outWord    (outWord),
        .outValid   (outValid),
        .outReady   (outReady),
        .busy       (busy),
        .frameDone  (frameDone)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison point: counts and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected beats of one frame built from the character model.
    task automatic pushFrame();
        expQ.push_back(9'h080);
        for (int c = 0; c < 16; c++) expQ.push_back({1'b1, model[c]});
        expQ.push_back(9'h0C0);
        for (int c = 16; c < 32; c++) expQ.push_back({1'b1, model[c]});
    endtask

    // Scoreboard monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rstBt) begin
            stallPrev = 1'b0;
        end else begin
            if (stallPrev) begin
                checkOutput("stallValid", 32'(outValid), 32'd1);
                checkOutput("stallWord", 32'(outWord), 32'(prevWord));
            end
            if (outValid && outReady) begin
                beatCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedBeatQueue", 32'(expQ.size()), 32'd1);
                end else begin
                    expWord = expQ.pop_front();
                    checkOutput($sformatf("beat%0d", beatCount), 32'(outWord), 32'(expWord));
                end
            end
            stallPrev = outValid && !outReady;
            prevWord  = outWord;
        end
    end

    task automatic writeCell(input logic [4:0] addr, input logic [7:0] data);
        @(posedge clk); #1;
        wrEn   = 1'b1;
        wrAddr = addr;
        wrData = data;
        model[addr] = data;
        @(posedge clk); #1;
        wrEn = 1'b0;
    endtask

    // Single-cycle refresh; checks the one-cycle latency to outValid.
    task automatic applyStimulus();
        @(posedge clk); #1;
        checkOutput("preRefreshValid", 32'(outValid), 32'd0);
        refreshReq = 1'b1;
        pushFrame();
        @(posedge clk); #1;
        refreshReq = 1'b0;
        checkOutput("latencyValid", 32'(outValid), 32'd1);
        checkOutput("latencyBusy", 32'(busy), 32'd1);
    endtask

    task automatic waitFrames(input string tag, input int nFrames, input int budget);
        int dones = 0;
        int cyc   = 0;
        while (dones < nFrames && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (frameDone) dones++;
        end
        checkOutput({tag, "_frameDoneCount"}, 32'(dones), 32'(nFrames));
        @(negedge clk);
        checkOutput({tag, "_busyAfter"}, 32'(busy), 32'd0);
        checkOutput({tag, "_frameDoneLow"}, 32'(frameDone), 32'd0);
        checkOutput({tag, "_queueEmpty"}, 32'(expQ.size()), 32'd0);
    endtask

    task automatic waitBeats(input string tag, input int target);
        for (int i = 0; i < 200 && beatCount < target; i++) @(posedge clk);
        checkOutput({tag, "_reached"}, 32'(beatCount >= target), 32'd1);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int validCycles;
        int dones;
        int seen;

        assertCount = 0;
        failCount   = 0;
        beatCount   = 0;
        stallPrev   = 1'b0;
        prevWord    = 9'h000;
        rstBt       = 1'b0;
        wrEn        = 1'b0;
        wrAddr      = 5'd0;
        wrData      = 8'h00;
        clrReq      = 1'b0;
        refreshReq  = 1'b0;
        outReady    = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 8'h20;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstValid", 32'(outValid), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstFrameDone", 32'(frameDone), 32'd0);
        checkOutput("rstWord", 32'(outWord), 32'h000);
        rstBt = 1'b1;

        // Blank frame, outReady held high: 34 beats.
        $display("[TB] blank frame");
        base = beatCount;
        applyStimulus();
        waitFrames("blank", 1, 100);
        checkOutput("blankBeats", 32'(beatCount - base), 32'd34);

        // HELLO on row 0 and 'W' at the start of row 1.
        $display("[TB] HELLO frame");
        writeCell(5'd0, 8'h48);
        writeCell(5'd1, 8'h45);
        writeCell(5'd2, 8'h4C);
        writeCell(5'd3, 8'h4C);
        writeCell(5'd4, 8'h4F);
        writeCell(5'd16, 8'h57);
        applyStimulus();
        waitFrames("hello", 1, 100);

        // outReady toggling every cycle: 34 beats over 67 valid cycles.
        $display("[TB] stalled frame");
        base = beatCount;
        applyStimulus();
        outReady    = 1'b1;
        validCycles = 0;
        dones       = 0;
        for (int i = 0; i < 200 && dones == 0; i++) begin
            if (outValid) validCycles++;
            @(posedge clk); #1;
            if (frameDone) dones++;
            outReady = ~outReady;
        end
        outReady = 1'b1;
        checkOutput("stallFrameDone", 32'(dones), 32'd1);
        checkOutput("stallValidCycles", 32'(validCycles), 32'd67);
        checkOutput("stallBeats", 32'(beatCount - base), 32'd34);
        checkOutput("stallQueueEmpty", 32'(expQ.size()), 32'd0);

        // Write during row 1: current frame keeps old cell 3, pending frame follows.
        $display("[TB] pending frame");
        base = beatCount;
        applyStimulus();
        waitBeats("row1", base + 20);
        writeCell(5'd3, 8'h41);
        pushFrame();
        seen = 0;
        for (int i = 0; i < 100 && seen == 0; i++) begin
            @(negedge clk);
            if (frameDone) seen = 1;
        end
        checkOutput("pendFirstDone", 32'(seen), 32'd1);
        checkOutput("pendIdleGap", 32'(outValid), 32'd0);
        @(negedge clk);
        checkOutput("pendRestartValid", 32'(outValid), 32'd1);
        checkOutput("pendRestartWord", 32'(outWord), 32'h080);
        waitFrames("pend", 1, 100);

        // Clear and write in the same cycle: clear wins.
        $display("[TB] clear beats write");
        @(posedge clk); #1;
        clrReq = 1'b1;
        wrEn   = 1'b1;
        wrAddr = 5'd7;
        wrData = 8'h5A;
        @(posedge clk); #1;
        clrReq = 1'b0;
        wrEn   = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 8'h20;
        applyStimulus();
        waitFrames("clear", 1, 100);

        // Reset mid-frame.
        $display("[TB] reset mid-frame");
        writeCell(5'd9, 8'h58);
        base = beatCount;
        applyStimulus();
        waitBeats("midReset", base + 10);
        #2;
        rstBt = 1'b0;
        #1;
        checkOutput("asyncRstValid", 32'(outValid), 32'd0);
        checkOutput("asyncRstBusy", 32'(busy), 32'd0);
        checkOutput("asyncRstWord", 32'(outWord), 32'h000);
        expQ.delete();
        for (int i = 0; i < 32; i++) model[i] = 8'h20;
        @(posedge clk);
        @(posedge clk); #1;
        rstBt = 1'b1;
        validCycles = 0;
        repeat (5) begin
            @(negedge clk);
            if (outValid || busy) validCycles++;
        end
        checkOutput("noAutoRestart", 32'(validCycles), 32'd0);
        applyStimulus();
        waitFrames("postReset", 1, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
